// File: rtl/tile_result_writer_pkg.sv
// tile_result_writer_pkg
// Shared defaults and FSM encoding for the tile result writer.
// DEF_ARRAYWIDTH : lanes per result row
// DEF_ACC_W      : accumulator lane width
// DEF_OUT_CH     : output channels per pixel (address row pitch)
// DEF_ADDR_W     : byte address width
package tile_result_writer_pkg;

  localparam int DEF_ARRAYWIDTH = 16;
  localparam int DEF_ACC_W      = 32;
  localparam int DEF_OUT_CH     = 64;
  localparam int DEF_ADDR_W     = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/tile_result_writer_requant_sat8.sv
// requant_sat8
// Combinational requantization of one signed accumulator lane to int8:
// round-half-up by adding 1<<(shift-1), arithmetic right shift, then
// saturate to [-128, 127].
// acc   : signed accumulator, ACC_W bits
// shift : right-shift amount, 0..31
// q     : saturated signed int8 result
module requant_sat8 #(
  parameter int ACC_W = 32
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [4:0]       shift,
  output logic [7:0]       q
);

  localparam logic signed [ACC_W:0] ONE     = 1;
  localparam logic signed [ACC_W:0] SAT_MAX = 127;
  localparam logic signed [ACC_W:0] SAT_MIN = -128;

  logic signed [ACC_W:0] acc_ext;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] shifted;

  // One extra bit of headroom so adding the rounding constant to a
  // near-maximum accumulator cannot overflow before the shift.
  always_comb begin
    acc_ext = {acc[ACC_W-1], acc};
    rnd     = (shift != 5'd0) ? (ONE << (shift - 5'd1)) : '0;
    sum     = acc_ext + rnd;
    shifted = sum >>> shift;
    if (shifted > SAT_MAX) begin
      q = 8'h7F;
    end else if (shifted < SAT_MIN) begin
      q = 8'h80;
    end else begin
      q = shifted[7:0];
    end
  end

endmodule

// File: rtl/tile_result_writer.sv
// tile_result_writer
// Accepts a tile descriptor, then consumes cfg_rows result rows, requantizes
// each lane to int8 and emits one memory write beat per row with per-lane
// byte addresses and a per-lane write strobe.
// clk, rst            : clock, asynchronous active-low reset
// cfg_*               : tile descriptor handshake and fields
// in_valid/in_ready   : result row handshake, in_data = ARRAYWIDTH accumulators
// wr_en/wr_ready      : write beat handshake
// wr_addr/wr_data     : per-lane byte address and int8 data
// wr_lane_valid       : per-lane strobe (latched lane mask while wr_en)
// busy, done          : not-idle flag, one-cycle tile completion pulse
module tile_result_writer
  import tile_result_writer_pkg::*;
#(
  parameter int ARRAYWIDTH = DEF_ARRAYWIDTH,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int OUT_CH     = DEF_OUT_CH,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [14:0]                  cfg_pix_base,
  input  logic [6:0]                   cfg_ch_base,
  input  logic [4:0]                   cfg_rows,
  input  logic [ARRAYWIDTH-1:0]        cfg_lane_mask,
  input  logic [4:0]                   cfg_shift,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ARRAYWIDTH*ACC_W-1:0]  in_data,
  output logic                         wr_en,
  input  logic                         wr_ready,
  output logic [ARRAYWIDTH*ADDR_W-1:0] wr_addr,
  output logic [ARRAYWIDTH-1:0]        wr_lane_valid,
  output logic [ARRAYWIDTH*8-1:0]      wr_data,
  output logic                         busy,
  output logic                         done
);

  state_t state;
  state_t state_next;

  logic [4:0]            row_cnt;
  logic [14:0]           pix_base_q;
  logic [6:0]            ch_base_q;
  logic [4:0]            rows_q;
  logic [ARRAYWIDTH-1:0] lane_mask_q;
  logic [4:0]            shift_q;

  logic cfg_fire;
  logic row_fire;

  logic [31:0]                  row_base;
  logic [ARRAYWIDTH*ADDR_W-1:0] addr_next;
  logic [ARRAYWIDTH*8-1:0]      data_next;

  assign cfg_ready     = (state == IDLE);
  // A new row may enter while the output register is empty or draining
  // on this same edge, which gives one beat per cycle under wr_ready=1.
  assign in_ready      = (state == RUN) && (!wr_en || wr_ready);
  assign cfg_fire      = cfg_valid && cfg_ready;
  assign row_fire      = in_valid && in_ready;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign wr_lane_valid = wr_en ? lane_mask_q : '0;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. DRAIN waits only for the last held beat to leave.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (cfg_fire) begin
          state_next = (cfg_rows == 5'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (row_fire && (row_cnt == rows_q - 5'd1)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!wr_en || wr_ready) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Per-lane byte addresses for the row about to be accepted. The 32-bit
  // intermediate is truncated to ADDR_W, giving silent wrap-around.
  always_comb begin
    row_base  = (32'(pix_base_q) + 32'(row_cnt)) * 32'(OUT_CH) + 32'(ch_base_q);
    addr_next = '0;
    for (int i = 0; i < ARRAYWIDTH; i++) begin
      addr_next[i*ADDR_W +: ADDR_W] = ADDR_W'(row_base + 32'(i));
    end
  end

  for (genvar gi = 0; gi < ARRAYWIDTH; gi++) begin : g_lane
    requant_sat8 #(.ACC_W(ACC_W)) u_requant (
      .acc   (in_data[gi*ACC_W +: ACC_W]),
      .shift (shift_q),
      .q     (data_next[gi*8 +: 8])
    );
  end

  // Descriptor latch, row counter and output beat register. A beat stays
  // put until accepted; a row accepted on the acceptance edge replaces it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_cnt     <= '0;
      pix_base_q  <= '0;
      ch_base_q   <= '0;
      rows_q      <= '0;
      lane_mask_q <= '0;
      shift_q     <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
    end else begin
      if (cfg_fire) begin
        row_cnt     <= '0;
        pix_base_q  <= cfg_pix_base;
        ch_base_q   <= cfg_ch_base;
        rows_q      <= cfg_rows;
        lane_mask_q <= cfg_lane_mask;
        shift_q     <= cfg_shift;
      end
      if (row_fire) begin
        wr_en   <= 1'b1;
        wr_addr <= addr_next;
        wr_data <= data_next;
        row_cnt <= row_cnt + 5'd1;
      end else if (wr_en && wr_ready) begin
        wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: doc/tile_result_writer.md
TILE_RESULT_WRITER -- requirements
Module: tile_result_writer

Interface
REQ-001 Parameters (name, default, meaning): ARRAYWIDTH, 16, lanes per result row; ACC_W, 32, accumulator lane width; OUT_CH, 64, total output channels per pixel; ADDR_W, 17, byte address width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 cfg_valid  in  1  tile descriptor valid.
REQ-005 cfg_ready  out  1  descriptor accepted when cfg_valid && cfg_ready.
REQ-006 cfg_pix_base  in  15  first output-pixel index of the tile.
REQ-007 cfg_ch_base  in  7  first output channel of the tile.
REQ-008 cfg_rows  in  5  result rows in the tile, 0..16.
REQ-009 cfg_lane_mask  in  ARRAYWIDTH  per-lane write enable for partial channel tiles.
REQ-010 cfg_shift  in  5  requantization right-shift amount.
REQ-011 in_valid  in  1  result row valid from the output buffer.
REQ-012 in_ready  out  1  row accepted when in_valid && in_ready.
REQ-013 in_data  in  ARRAYWIDTH*ACC_W  signed accumulators; lane i at [i*ACC_W +: ACC_W].
REQ-014 wr_en  out  1  write beat valid.
REQ-015 wr_ready  in  1  memory accepts the beat when wr_en && wr_ready.
REQ-016 wr_addr  out  ARRAYWIDTH*ADDR_W  per-lane byte address; lane i at [i*ADDR_W +: ADDR_W].
REQ-017 wr_lane_valid  out  ARRAYWIDTH  per-lane write strobe.
REQ-018 wr_data  out  ARRAYWIDTH*8  signed int8 per lane.
REQ-019 busy  out  1  high in any state other than IDLE.
REQ-020 done  out  1  one-cycle pulse at tile completion.

Function
REQ-021 FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: cfg_ready=1. On accept, latch all cfg_* and clear row counter; go to RUN, or to DONE if cfg_rows=0.
REQ-022 RUN: in_ready = !wr_en || wr_ready. Each accepted row loads the output register and increments the row counter. When the accepted row is row cfg_rows-1, go to DRAIN.
REQ-023 DRAIN: in_ready=0. When wr_en=0, or on the cycle the final beat is accepted, go to DONE.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE; cfg_ready=0 in RUN, DRAIN and DONE.
REQ-025 Latency: row accepted at edge N gives wr_en=1 with its data from the cycle after edge N.
- While wr_en && !wr_ready, wr_en, wr_addr, wr_data and wr_lane_valid are held stable.
- wr_en clears after acceptance unless a new row is accepted on the same edge.
- Back-to-back rows sustain one beat per cycle when wr_ready=1.
REQ-026 Address of lane i for row r: ((pix_base + r) * OUT_CH + ch_base + i) modulo 2^ADDR_W (silent wrap-around, no error).
REQ-027 wr_lane_valid = latched cfg_lane_mask while wr_en=1, else 0.
REQ-028 Requantization per lane, computed in ACC_W+1 bits:
- v = acc + (shift>0 ? 1<<(shift-1) : 0);
- arithmetic right shift by shift;
- saturate to [-128, 127].
REQ-029 in_valid outside RUN is ignored (not consumed). cfg_valid outside IDLE is ignored.
REQ-030 wr_ready while wr_en=0 has no effect.

Reset
REQ-031 rst=0 asynchronously forces: state=IDLE, row counter=0, wr_en=0, wr_lane_valid=0, wr_addr=0, wr_data=0, done=0, busy=0, in_ready=0. cfg_ready is 1 in IDLE, from the first cycle after reset release.
REQ-032 Reset mid-tile discards the tile and any held beat; no done pulse is produced.

Structure
REQ-033 A shared package holds ARRAYWIDTH, ACC_W, ADDR_W, OUT_CH defaults and the FSM state encoding.
REQ-034 Per-lane requantization is one sub-module, requant_sat8 (ACC_W in, shift in, int8 out, combinational), instantiated ARRAYWIDTH times.

Verification
REQ-035 Basic tile: pix_base=0, ch_base=0, rows=2, mask=FFFF, shift=0, all lanes=5, wr_ready=1 -> 2 beats:
- addrs 0..15 then 64..79, data 0x05;
- done pulses once, 1 cycle after the last beat.
REQ-036 Saturation/rounding: shift=4, lanes {300*16, -5000, 23, 24} -> data {127, -128, 1, 2} (23+8=31>>4=1, 24+8=32>>4=2).
REQ-037 Backpressure: wr_ready=0 for 3 cycles during rows=3 -> beat held stable, in_ready=0, no row lost; 3 beats total in order.
REQ-038 Boundary:
- rows=0 -> cfg_ready=1 to done pulse in 2 cycles, no wr_en;
- pix_base=0x7FFF, ch_base=0, OUT_CH=64 -> lane-0 addr = (0x7FFF*64) mod 2^17 = 0x1FFC0.
REQ-039 Mask/reset: mask=0x00FF -> wr_lane_valid=0x00FF. rst=0 asserted mid-tile (after row 1 of 4) -> all outputs 0 immediately; next tile runs correctly; no stale done.
